// File: rtl/timer_note_master.sv
// Avalon-MM master that programs an interval timer per note and waits for its irq.
// Optional status read-back of the TO bit is enabled by defining TNM_STATUS_CHECK_EN.
module timer_note_master #(
  parameter int unsigned MIN_PERIOD = 8,
  parameter logic [3:0]  CTRL_GO    = 4'h5,
  parameter logic [3:0]  CTRL_HALT  = 4'h8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_period,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic        err,
  output logic [2:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [15:0] m_writedata,
  input  logic [15:0] m_readdata,
  input  logic        irq
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTRL, S_WAIT_IRQ,
    S_RD_STAT, S_RD_WAIT, S_WR_STOP, S_CLR_STAT, S_FIN
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] per_q, per_d;
  logic        lat_q, lat_d;
  logic        abg_q, abg_d;
  logic        cs_d, wrn_d;
  logic [2:0]  addr_d;
  logic [15:0] wdata_d;
  logic        done_d, abd_d;

`ifdef TNM_STATUS_CHECK_EN
  logic err_q, err_d;
  assign err = err_q;
`else
  logic unused_rd;
  assign unused_rd = ^m_readdata;
  assign err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    lat_d   = lat_q;
    abg_d   = abg_q;
`ifdef TNM_STATUS_CHECK_EN
    err_d   = err_q;
`endif
    if (state_q != S_IDLE && abort) lat_d = 1'b1;
    unique case (state_q)
      S_IDLE: if (cmd_valid) begin
        per_d   = (cmd_period < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : cmd_period;
        lat_d   = 1'b0;
        abg_d   = 1'b0;
`ifdef TNM_STATUS_CHECK_EN
        err_d   = 1'b0;
`endif
        state_d = S_WR_PL;
      end
      S_WR_PL:   state_d = S_WR_PH;
      S_WR_PH:   state_d = S_WR_CTRL;
      S_WR_CTRL: state_d = S_WAIT_IRQ;
      S_WAIT_IRQ: begin
        if (irq) begin
          lat_d = 1'b0;
`ifdef TNM_STATUS_CHECK_EN
          state_d = S_RD_STAT;
`else
          state_d = S_CLR_STAT;
`endif
        end else if (lat_q) begin
          state_d = S_WR_STOP;
        end
      end
      S_RD_STAT: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
`ifdef TNM_STATUS_CHECK_EN
        if (!m_readdata[0]) err_d = 1'b1;
`endif
        state_d = S_CLR_STAT;
      end
      S_WR_STOP: begin
        abg_d   = 1'b1;
        state_d = S_CLR_STAT;
      end
      S_CLR_STAT: state_d = S_FIN;
      S_FIN:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so they line up with it.
  always_comb begin
    cs_d    = 1'b0;
    wrn_d   = 1'b1;
    addr_d  = 3'd0;
    wdata_d = 16'h0;
    unique case (state_d)
      S_WR_PL: begin
        cs_d = 1'b1; wrn_d = 1'b0; addr_d = 3'd2; wdata_d = per_d[15:0];
      end
      S_WR_PH: begin
        cs_d = 1'b1; wrn_d = 1'b0; addr_d = 3'd3; wdata_d = per_d[31:16];
      end
      S_WR_CTRL: begin
        cs_d = 1'b1; wrn_d = 1'b0; addr_d = 3'd1; wdata_d = {12'h0, CTRL_GO};
      end
      S_WR_STOP: begin
        cs_d = 1'b1; wrn_d = 1'b0; addr_d = 3'd1; wdata_d = {12'h0, CTRL_HALT};
      end
      S_RD_STAT:  cs_d = 1'b1;
      S_CLR_STAT: begin
        cs_d = 1'b1; wrn_d = 1'b0;
      end
      default: ;
    endcase
    done_d = (state_d == S_FIN) && !abg_d;
    abd_d  = (state_d == S_FIN) && abg_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      per_q        <= 32'h0;
      lat_q        <= 1'b0;
      abg_q        <= 1'b0;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_address    <= 3'd0;
      m_writedata  <= 16'h0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
`ifdef TNM_STATUS_CHECK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      per_q        <= per_d;
      lat_q        <= lat_d;
      abg_q        <= abg_d;
      m_chipselect <= cs_d;
      m_write_n    <= wrn_d;
      m_address    <= addr_d;
      m_writedata  <= wdata_d;
      done         <= done_d;
      aborted      <= abd_d;
      cmd_ready    <= (state_d == S_IDLE);
      busy         <= (state_d != S_IDLE);
`ifdef TNM_STATUS_CHECK_EN
      err_q        <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_timer_note_master.sv
// Bench for timer_note_master: directed and random notes against a reference
// of the expected bus transactions and completion pulses.
module tb_timer_note_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [31:0] cmd_period = 32'h0;
  logic        abort = 1'b0;
  logic        irq = 1'b0;
  logic [15:0] m_readdata;
  logic        cmd_ready, busy, done, aborted, err;
  logic [2:0]  m_address;
  logic        m_chipselect, m_write_n;
  logic [15:0] m_writedata;
  logic        to_bit = 1'b1;

  int compared = 0;
  int mismatched = 0;

  timer_note_master dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_period(cmd_period),
    .abort(abort), .busy(busy), .done(done), .aborted(aborted), .err(err),
    .m_address(m_address), .m_chipselect(m_chipselect),
    .m_write_n(m_write_n), .m_writedata(m_writedata),
    .m_readdata(m_readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  // Status register read returns the TO bit one cycle after the address.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) m_readdata <= 16'h0;
    else m_readdata <= (m_chipselect && m_write_n && m_address == 3'd0)
                       ? {15'h0, to_bit} : 16'h0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] ent(input bit wr, input logic [2:0] a,
                                     input logic [15:0] d);
    return {wr, a, d};
  endfunction

  // mode 0: normal, irq after dly; 1: abort pulse in WR_PH, no irq;
  // 2: irq and abort together at the start of the wait; 3: abort after dly.
  task automatic run_cmd(input logic [31:0] per, input int mode,
                         input int dly, input bit tb);
    logic [19:0] obs[$];
    logic [19:0] exq[$];
    int          cyc[$];
    logic [31:0] p;
    bit          abg, fin;
    int          t, d, n_done, n_ab;
    logic        exp_err;
    p = (per < 32'd8) ? 32'd8 : per;
    abg = (mode == 1 || mode == 3);
    d = (mode == 2) ? 0 : dly;
    exq.push_back(ent(1, 3'd2, p[15:0]));
    exq.push_back(ent(1, 3'd3, p[31:16]));
    exq.push_back(ent(1, 3'd1, 16'h5));
    exp_err = 1'b0;
    if (abg) exq.push_back(ent(1, 3'd1, 16'h8));
    else begin
`ifdef TNM_STATUS_CHECK_EN
      exq.push_back(ent(0, 3'd0, 16'h0));
      exp_err = !tb;
`endif
    end
    exq.push_back(ent(1, 3'd0, 16'h0));
    to_bit = tb;
    @(negedge clk);
    chk("ready_before", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_period = per;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_period = $urandom;
    chk("err_cleared", err, 0);
    t = -1; fin = 0; n_done = 0; n_ab = 0;
    for (int c = 0; c < d + 40 && !fin; c++) begin
      if (c > 0) @(negedge clk);
      abort = (mode == 2 && t == 0);
      if (m_chipselect) begin
        obs.push_back({!m_write_n, m_address, m_writedata});
        cyc.push_back(c);
      end
      if (done) n_done++;
      if (aborted) n_ab++;
      if (done || aborted) begin
        fin = 1;
        chk("busy_fin", busy, 1);
        chk("ready_fin", cmd_ready, 0);
        chk("err_fin", err, exp_err);
      end
      if (t >= 0) t++;
      else if (m_chipselect && !m_write_n && m_address == 3'd1
               && m_writedata == 16'h5) t = 0;
      if (mode == 1 && m_chipselect && !m_write_n && m_address == 3'd3)
        abort = 1'b1;
      if (t == d) begin
        if (mode == 0 || mode == 2) irq = 1'b1;
        if (mode == 2 || mode == 3) abort = 1'b1;
      end
      if (m_chipselect && !m_write_n && m_address == 3'd0) irq = 1'b0;
    end
    chk("finished", fin, 1);
    @(negedge clk);
    abort = 1'b0;
    irq = 1'b0;
    chk("ready_after", cmd_ready, 1);
    chk("busy_after", busy, 0);
    chk("done_after", done, 0);
    chk("n_bus", obs.size(), exq.size());
    for (int i = 0; i < obs.size() && i < exq.size(); i++)
      chk($sformatf("bus%0d", i), obs[i], exq[i]);
    if (cyc.size() >= 3) begin
      chk("b2b0", cyc[0], 0);
      chk("b2b1", cyc[1], 1);
      chk("b2b2", cyc[2], 2);
    end
    chk("n_done", n_done, abg ? 0 : 1);
    chk("n_aborted", n_ab, abg ? 1 : 0);
  endtask

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    chk("rst_cs", m_chipselect, 0);
    chk("rst_wrn", m_write_n, 1);
    chk("rst_addr", m_address, 0);
    chk("rst_wdata", m_writedata, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);

    run_cmd(32'h0001_86A0, 0, 3, 1'b1);
    run_cmd(32'h0000_0003, 0, 8, 1'b1);
    run_cmd(32'h1234_5678, 1, 0, 1'b1);
    run_cmd(32'd20, 2, 0, 1'b1);
    run_cmd(32'd50, 3, 4, 1'b1);
    run_cmd(32'd50, 0, 2, 1'b0);
    run_cmd(32'd50, 0, 1, 1'b1);
    run_cmd(32'd0, 0, 0, 1'b1);
    run_cmd(32'd7, 0, 1, 1'b1);
    run_cmd(32'd8, 0, 1, 1'b1);
    run_cmd(32'd9, 0, 1, 1'b1);
    run_cmd(32'hFFFF_FFFF, 0, 2, 1'b1);

    // Reset while waiting for irq.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_period = 32'd100;
    @(negedge clk);
    cmd_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (m_chipselect && !m_write_n && m_address == 3'd1) seen = 1;
      else @(negedge clk);
    end
    chk("rst_mid_ctrl_seen", seen, 1);
    repeat (2) @(negedge clk);
    chk("rst_mid_busy_before", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_cs", m_chipselect, 0);
    chk("rst_mid_wrn", m_write_n, 1);
    chk("rst_mid_busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_mid_nodone", {done, aborted}, 0);
    end
    run_cmd(32'd100, 0, 2, 1'b1);

    for (int n = 0; n < 16; n++) begin
      logic [31:0] per;
      per = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      run_cmd(per, int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
              1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/timer_note_master.md
Name: timer_note_master

Overview:
Avalon-MM master that drives a 16-bit interval-timer slave with a 3-bit word address to time note durations for the music player.
- Accepts a 32-bit period command over a valid/ready handshake.
- Programs period_l, period_h and control, then waits for the timer irq.
- Clears the timer status and pulses done.
- Sits between the note sequencer and the timer slave, in place of CPU-driven timer servicing.

Parameters:
MIN_PERIOD, 8, smallest period written to the timer; smaller requests are clamped up to this value.
CTRL_GO, 4'h5, control word written to start a note (bit0 ITO=1, bit1 CONT=0, bit2 START=1, bit3 STOP=0).
CTRL_HALT, 4'h8, control word written on abort (bit3 STOP=1).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  period command valid
cmd_ready  out  1  high only in IDLE
cmd_period  in  32  timer period in clk cycles (counter reload value)
abort  in  1  level; request to cancel the current note
busy  out  1  high in every state except IDLE
done  out  1  1-cycle pulse: note completed normally
aborted  out  1  1-cycle pulse: note cancelled
err  out  1  sticky status-check failure; cleared on next command accept
m_address  out  3  timer word address (0 status, 1 control, 2 period_l, 3 period_h)
m_chipselect  out  1  slave select
m_write_n  out  1  active-low write
m_writedata  out  16  write data
m_readdata  in  16  slave read data, valid the cycle after the address is presented
irq  in  1  timer interrupt, level

Behaviour:
- Reset (async, reset_n low): all bus outputs idle (chipselect=0, write_n=1, address=0, writedata=0). done=0, aborted=0, err=0, busy=0, state=IDLE, so cmd_ready=1 once reset releases.
- All outputs are registered. No waitrequest: every write completes in its single cycle, and consecutive accesses run back-to-back.
- A write cycle is chipselect=1, write_n=0, with address and writedata valid. A read cycle is chipselect=1, write_n=1.
- Command accept: on cmd_valid && cmd_ready, latch P = max(cmd_period, MIN_PERIOD) (unsigned compare), clear err and the abort latch, and go to WR_PL.
- States and transitions:
  - IDLE: wait for accept, then WR_PL.
  - WR_PL: write addr 2, data P[15:0]; go to WR_PH.
  - WR_PH: write addr 3, data P[31:16]; go to WR_CTRL.
  - WR_CTRL: write addr 1, data {12'b0, CTRL_GO}; go to WAIT_IRQ. Period writes precede the start write because the slave's period-write force-reload stops the counter; the start write lands in or after the force-reload cycle and the slave gives start priority.
  - WAIT_IRQ: bus idle. If irq=1, go to RD_STAT (or CLR_STAT without the optional feature). Otherwise, if abort_lat=1, go to WR_STOP.
  - WR_STOP: write addr 1, data {12'b0, CTRL_HALT}; go to CLR_STAT with aborting=1.
  - CLR_STAT: write addr 0, data 0; go to FIN.
  - FIN: bus idle. Pulse done (or aborted if aborting=1) for 1 cycle; go to IDLE.
- Abort latching:
  - abort is sampled in every busy state and latched into abort_lat.
  - It acts only in WAIT_IRQ, so programming is never interrupted mid-sequence.
  - irq has priority over abort in the same WAIT_IRQ cycle: the note completes normally and the abort latch is discarded.
- irq is sampled only in WAIT_IRQ. The slave drops irq one cycle after the status write, so FIN/IDLE never retrigger.
- cmd_valid during FIN is not accepted; the command is accepted in the following IDLE cycle. Minimum command-to-command spacing without the optional feature: 6 cycles plus the irq wait.
- Reset mid-operation: the bus returns idle immediately and no done/aborted pulse is produced. The timer shares reset_n.

Optional Feature:
TNM_STATUS_CHECK_EN:
- Defined: after irq, the master runs two extra states before CLR_STAT.
  - RD_STAT: read cycle at addr 0.
  - RD_WAIT: bus idle; capture m_readdata[0] (TO bit).
  - If TO=0, set err=1. Flow continues to CLR_STAT either way.
- Undefined: WAIT_IRQ goes directly to CLR_STAT, and err is tied 0.

Test Plan:
1. cmd_period=0x0001_86A0 accepted -> consecutive writes (2,0x86A0), (3,0x0001), (1,0x0005); on irq, write (0,0x0000), then done pulses once and cmd_ready returns to 1.
2. cmd_period=0x0000_0003, MIN_PERIOD=8 -> writes (2,0x0008), (3,0x0000); with the slave model, irq arrives within 8+4 cycles of the control write.
3. abort pulsed during WR_PH, irq held low -> all three programming writes complete, then writes (1,0x0008), (0,0x0000); aborted pulses, done stays 0.
4. irq and abort both high in the first WAIT_IRQ cycle -> normal completion: done=1, aborted=0, no (1,0x0008) write.
5. TNM_STATUS_CHECK_EN defined; bench model raises irq with status readdata=0x0000 -> read cycle at addr 0, err=1 after RD_WAIT, done still pulses; next command accept clears err to 0.
6. reset_n low for 1 cycle while in WAIT_IRQ -> chipselect=0, write_n=1, busy=0 immediately; no done; next command runs the full sequence from WR_PL.
